// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_tx_arbiter : 4-way round-robin arbiter feeding a 7-bit + parity framer
// Revision          : 1.0
// ----------------------------------------------------------------------------
module serial_tx_arbiter #(
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  req_valid,
  input  logic [27:0] req_data,
  input  logic [3:0]  req_err_inject,
  output logic [3:0]  req_ready,
  output logic        serial_out,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  state_t     state, state_next;
  logic [1:0] last_grant;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic       accept;
  logic [6:0] sel_data;
  logic [6:0] payload;
  logic       parity_bit;
  logic [2:0] bit_cnt;
  logic [3:0] stop_cnt;
  logic       serial_next;
  logic       done_next;

  // Search starts one past the last granted requester and wraps.
  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    case (winner)
      2'd0:    sel_data = req_data[6:0];
      2'd1:    sel_data = req_data[13:7];
      2'd2:    sel_data = req_data[20:14];
      default: sel_data = req_data[27:21];
    endcase
  end

  always_comb begin
    state_next  = state;
    req_ready   = 4'b0000;
    accept      = 1'b0;
    serial_next = serial_out;
    done_next   = 1'b0;
    case (state)
      IDLE: begin
        serial_next = 1'b1;
        if (found && rstn) begin
          req_ready[winner] = 1'b1;
          accept            = 1'b1;
          state_next        = START;
          serial_next       = 1'b0;
        end
      end
      START: begin
        serial_next = payload[0];
        state_next  = DATA;
      end
      DATA: begin
        // payload is shifted right as bits go out, so bit 0 is always next
        if (bit_cnt == 3'd6) begin
          serial_next = parity_bit;
          state_next  = PARITY;
        end else begin
          serial_next = payload[0];
        end
      end
      PARITY: begin
        serial_next = 1'b1;
        state_next  = STOP;
      end
      STOP: begin
        serial_next = 1'b1;
        if (stop_cnt == STOP_LAST) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        serial_next = 1'b1;
        state_next  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      serial_out <= 1'b1;
      frame_done <= 1'b0;
      grant_id   <= 2'd0;
      last_grant <= 2'd3;
      payload    <= 7'd0;
      parity_bit <= 1'b0;
      bit_cnt    <= 3'd0;
      stop_cnt   <= 4'd0;
    end else begin
      serial_out <= serial_next;
      frame_done <= done_next;
      if (accept) begin
        grant_id   <= winner;
        last_grant <= winner;
        payload    <= sel_data;
        parity_bit <= (^sel_data) ^ req_err_inject[winner];
      end else if (state == START || (state == DATA && bit_cnt != 3'd6)) begin
        payload <= {1'b0, payload[6:1]};
      end
      bit_cnt  <= (state == DATA) ? bit_cnt + 3'd1 : 3'd0;
      stop_cnt <= (state == STOP) ? stop_cnt + 4'd1 : 4'd0;
    end
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
`default_nettype none
// Directed bench for serial_tx_arbiter: one instance with 1 stop bit, one with 3.
module tb_serial_tx_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req_valid = 4'd0;
  logic [27:0] req_data = 28'd0;
  logic [3:0]  req_err_inject = 4'd0;

  logic [3:0]  ready1, ready3;
  logic        ser1, ser3, busy1, busy3, done1, done3;
  logic [1:0]  gid1, gid3;

  int checks = 0;
  int failures = 0;

  serial_tx_arbiter #(.STOP_BITS(1)) dut1 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_err_inject(req_err_inject), .req_ready(ready1), .serial_out(ser1),
    .busy(busy1), .grant_id(gid1), .frame_done(done1)
  );

  serial_tx_arbiter #(.STOP_BITS(3)) dut3 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_err_inject(req_err_inject), .req_ready(ready3), .serial_out(ser3),
    .busy(busy3), .grant_id(gid3), .frame_done(done3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_valid = 4'd0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // Records line state for len cycles starting with the cycle after accept.
  task automatic capture(input bit use3, input int len, output logic [24:0] ser,
                         output logic [24:0] bsy, output logic [24:0] dn);
    ser = '1;
    bsy = '0;
    dn  = '0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) tick();
      ser[i] = use3 ? ser3  : ser1;
      bsy[i] = use3 ? busy3 : busy1;
      dn[i]  = use3 ? done3 : done1;
    end
  endtask

  function automatic logic [24:0] exp_ser(input logic [6:0] d, input logic inj);
    logic [24:0] v;
    v = '1;
    v[0] = 1'b0;
    for (int i = 0; i < 7; i++) v[i+1] = d[i];
    v[8] = (^d) ^ inj;
    return v;
  endfunction

  function automatic logic [24:0] exp_busy(input int len);
    logic [24:0] v;
    v = '0;
    for (int i = 0; i < len - 1; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [24:0] exp_done(input int len);
    logic [24:0] v;
    v = '0;
    v[len-1] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    req_valid = 4'hF;
    req_data = {7'h44, 7'h33, 7'h22, 7'h11};
    tick();
    tick();
    checks++; if (ready1 !== 4'b0000) begin failures++; $display("FAIL reset_ready1: got %b expected 0000", ready1); end
    checks++; if (ready3 !== 4'b0000) begin failures++; $display("FAIL reset_ready3: got %b expected 0000", ready3); end
    checks++; if (ser1 !== 1'b1) begin failures++; $display("FAIL reset_serial: got %b expected 1", ser1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    checks++; if (gid1 !== 2'd0) begin failures++; $display("FAIL reset_grant_id: got %0d expected 0", gid1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b expected 0", done1); end
    rstn = 1'b1;
    #1;
    checks++; if (ready1 !== 4'b0001) begin failures++; $display("FAIL first_cycle_ready: got %b expected 0001", ready1); end
    tick();
    checks++; if (busy1 !== 1'b1 || ser1 !== 1'b0) begin failures++; $display("FAIL first_cycle_accept: busy=%b serial=%b expected busy=1 serial=0", busy1, ser1); end
    req_valid = 4'd0;
  endtask

  task automatic test_parity_55();
    logic [24:0] s, b, d;
    do_reset();
    req_data = 28'd0;
    req_data[6:0] = 7'h55;
    req_err_inject = 4'd0;
    req_valid = 4'b0001;
    #1;
    checks++; if (ready1 !== 4'b0001) begin failures++; $display("FAIL p55_ready: got %b expected 0001", ready1); end
    tick();
    req_valid = 4'd0;
    capture(1'b0, 11, s, b, d);
    checks++; if (s[10:0] !== 11'b11010101010) begin failures++; $display("FAIL p55_serial: got %b expected 11010101010", s[10:0]); end
    checks++; if (s[8] !== 1'b0) begin failures++; $display("FAIL p55_parity: got %b expected 0", s[8]); end
    checks++; if (b !== exp_busy(11)) begin failures++; $display("FAIL p55_busy: got %h expected %h", b, exp_busy(11)); end
    checks++; if (d !== exp_done(11)) begin failures++; $display("FAIL p55_frame_done: got %h expected %h", d, exp_done(11)); end
    checks++; if (gid1 !== 2'd0) begin failures++; $display("FAIL p55_grant_id: got %0d expected 0", gid1); end
  endtask

  task automatic test_round_robin();
    logic [24:0] s, b, d;
    logic [6:0]  rr_data [4];
    logic [3:0]  exp_rdy;
    rr_data = '{7'h11, 7'h22, 7'h33, 7'h44};
    do_reset();
    req_data = {7'h44, 7'h33, 7'h22, 7'h11};
    req_err_inject = 4'd0;
    req_valid = 4'hF;
    for (int g = 0; g < 4; g++) begin
      #1;
      exp_rdy = 4'(1 << g);
      checks++; if (ready1 !== exp_rdy) begin failures++; $display("FAIL rr_ready_%0d: got %b expected %b", g, ready1, exp_rdy); end
      tick();
      capture(1'b0, 11, s, b, d);
      checks++; if (gid1 !== 2'(g)) begin failures++; $display("FAIL rr_grant_id_%0d: got %0d expected %0d", g, gid1, g); end
      checks++; if (s !== exp_ser(rr_data[g], 1'b0)) begin failures++; $display("FAIL rr_serial_%0d: got %h expected %h", g, s, exp_ser(rr_data[g], 1'b0)); end
      checks++; if (d !== exp_done(11) || b !== exp_busy(11)) begin failures++; $display("FAIL rr_timing_%0d: done=%h busy=%h expected done=%h busy=%h", g, d, b, exp_done(11), exp_busy(11)); end
    end
    #1;
    checks++; if (ready1 !== 4'b0001) begin failures++; $display("FAIL rr_wrap_ready: got %b expected 0001", ready1); end
    req_valid = 4'd0;
  endtask

  task automatic test_err_inject();
    logic [24:0] s, b, d;
    do_reset();
    req_data = 28'd0;
    req_data[13:7] = 7'h01;
    req_err_inject = 4'b0010;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'd0;
    req_err_inject = 4'd0;
    req_data = '1;
    capture(1'b0, 11, s, b, d);
    checks++; if (s[8] !== 1'b0) begin failures++; $display("FAIL inj_parity: got %b expected 0", s[8]); end
    checks++; if (s !== exp_ser(7'h01, 1'b1)) begin failures++; $display("FAIL inj_serial: got %h expected %h", s, exp_ser(7'h01, 1'b1)); end
    checks++; if ((^s[8:1]) !== 1'b1) begin failures++; $display("FAIL inj_rx_parity_error: got %b expected 1", ^s[8:1]); end
    checks++; if (gid1 !== 2'd1) begin failures++; $display("FAIL inj_grant_id: got %0d expected 1", gid1); end
  endtask

  task automatic test_midframe_reset();
    logic any_done, any_low, any_busy;
    do_reset();
    req_data = 28'd0;
    req_data[6:0] = 7'h33;
    req_err_inject = 4'd0;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'd0;
    repeat (4) tick();
    checks++; if (ser1 !== 1'b0 || busy1 !== 1'b1) begin failures++; $display("FAIL mid_bit3: serial=%b busy=%b expected serial=0 busy=1", ser1, busy1); end
    #3;
    rstn = 1'b0;
    #1;
    checks++; if (ser1 !== 1'b1 || busy1 !== 1'b0) begin failures++; $display("FAIL mid_async_reset: serial=%b busy=%b expected serial=1 busy=0", ser1, busy1); end
    tick();
    rstn = 1'b1;
    any_done = 1'b0;
    any_low = 1'b0;
    any_busy = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      any_done |= done1;
      any_low  |= ~ser1;
      any_busy |= busy1;
    end
    checks++; if (any_done !== 1'b0) begin failures++; $display("FAIL mid_no_frame_done: got %b expected 0", any_done); end
    checks++; if (any_low !== 1'b0 || any_busy !== 1'b0) begin failures++; $display("FAIL mid_no_reoffer: low=%b busy=%b expected 0 0", any_low, any_busy); end
    req_valid = 4'b0101;
    #1;
    checks++; if (ready1 !== 4'b0001) begin failures++; $display("FAIL mid_priority_ready: got %b expected 0001", ready1); end
    tick();
    checks++; if (gid1 !== 2'd0 || ser1 !== 1'b0) begin failures++; $display("FAIL mid_priority_accept: grant_id=%0d serial=%b expected 0 0", gid1, ser1); end
    req_valid = 4'd0;
  endtask

  task automatic test_stop3();
    logic [24:0] s, b, d;
    do_reset();
    req_data = 28'd0;
    req_data[20:14] = 7'h2A;
    req_err_inject = 4'd0;
    req_valid = 4'b0100;
    #1;
    checks++; if (ready3 !== 4'b0100) begin failures++; $display("FAIL s3_ready: got %b expected 0100", ready3); end
    for (int f = 0; f < 2; f++) begin
      tick();
      capture(1'b1, 13, s, b, d);
      checks++; if (s !== exp_ser(7'h2A, 1'b0)) begin failures++; $display("FAIL s3_serial_%0d: got %h expected %h", f, s, exp_ser(7'h2A, 1'b0)); end
      checks++; if (b !== exp_busy(13)) begin failures++; $display("FAIL s3_busy_%0d: got %h expected %h", f, b, exp_busy(13)); end
      checks++; if (d !== exp_done(13)) begin failures++; $display("FAIL s3_frame_done_%0d: got %h expected %h", f, d, exp_done(13)); end
      checks++; if (gid3 !== 2'd2) begin failures++; $display("FAIL s3_grant_id_%0d: got %0d expected 2", f, gid3); end
      #1;
      checks++; if (ready3 !== 4'b0100) begin failures++; $display("FAIL s3_period_ready_%0d: got %b expected 0100", f, ready3); end
    end
    req_valid = 4'd0;
  endtask

  task automatic test_loopback();
    logic [24:0] s, b, d;
    logic [6:0]  dat;
    logic        inj;
    int          k;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      k   = $urandom_range(0, 3);
      dat = 7'($urandom);
      inj = 1'($urandom);
      req_data = 28'($urandom);
      req_data[7*k +: 7] = dat;
      req_err_inject = 4'($urandom);
      req_err_inject[k] = inj;
      req_valid = 4'(1 << k);
      tick();
      req_valid = 4'd0;
      req_data = 28'($urandom);
      req_err_inject = 4'($urandom);
      capture(1'b0, 11, s, b, d);
      checks++; if (s[0] !== 1'b0 || s[10:9] !== 2'b11) begin failures++; $display("FAIL lb_framing_%0d: start=%b stop/idle=%b expected 0 11", n, s[0], s[10:9]); end
      checks++; if (s[7:1] !== dat) begin failures++; $display("FAIL lb_data_%0d: got %h expected %h", n, s[7:1], dat); end
      checks++; if ((^s[8:1]) !== inj) begin failures++; $display("FAIL lb_parity_error_%0d: got %b expected %b", n, ^s[8:1], inj); end
      checks++; if (gid1 !== 2'(k)) begin failures++; $display("FAIL lb_grant_id_%0d: got %0d expected %0d", n, gid1, k); end
    end
  endtask

  initial begin
    test_reset();
    test_parity_55();
    test_round_robin();
    test_err_inject();
    test_midframe_reset();
    test_stop3();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_tx_arbiter.md
SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 Parameter: STOP_BITS, 1, number of idle-high cycles after the parity bit (legal range 1..15).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  4  per-requester frame request; bit i belongs to requester i.
REQ-005 req_data  input  28  requester i payload on bits [7i+6:7i], 7 bits.
REQ-006 req_err_inject  input  4  per-requester flag, sampled at accept; when set, the transmitted parity bit is inverted.
REQ-007 req_ready  output  4  one-hot accept strobe; a transfer occurs on a rising edge with req_valid[i] and req_ready[i] both high.
REQ-008 serial_out  output  1  registered serial line, idle high.
REQ-009 busy  output  1  high from the cycle after accept through the last stop cycle.
REQ-010 grant_id  output  2  index of the requester accepted most recently; holds between frames.
REQ-011 frame_done  output  1  one-cycle pulse in the cycle after the last stop cycle.

Function
REQ-012 Frame format, one bit per clk: start 0, data[0]..data[6] LSB first, parity, then STOP_BITS cycles of 1.
REQ-013 Parity bit = XOR of the 7 data bits (even parity over 8 bits), XOR req_err_inject of the accepted requester.
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP; DATA uses a 3-bit counter 0..6; STOP uses a 4-bit counter 0..STOP_BITS-1.
REQ-015 IDLE: serial_out=1, busy=0; req_ready asserted combinationally for exactly one winner when any req_valid is high, else all zero.
REQ-016 Transitions: IDLE->START on accept; START->DATA after 1 cycle; DATA->PARITY after 7 cycles; PARITY->STOP after 1 cycle; STOP->IDLE after STOP_BITS cycles.
REQ-017 Latency: accept at edge T; serial_out=0 in cycle T+1, data T+2..T+8, parity T+9, stop T+10..T+9+STOP_BITS; next accept no earlier than cycle T+10+STOP_BITS.
REQ-018 Minimum frame period with continuous requests = 10+STOP_BITS cycles.
REQ-019 Arbitration is round-robin: search starts at (last_grant+1) mod 4 and wraps; after reset last_grant=3, so requester 0 has top priority.
REQ-020 Payload and err_inject are captured into internal registers at accept; requester inputs are don't-care after accept.
REQ-021 req_ready is zero in every non-IDLE state; req_valid changes outside IDLE have no effect.
REQ-022 A requester may drop req_valid before accept without penalty; the pointer advances only on an accept.
REQ-023 grant_id updates on the accept edge.
REQ-024 frame_done and the IDLE accept cycle coincide, allowing a new accept in the same cycle frame_done is high.

Reset
REQ-025 While rstn is low: serial_out=1, busy=0, req_ready=0, grant_id=0, frame_done=0, state IDLE, last_grant=3, counters 0.
REQ-026 Reset assertion mid-frame drives serial_out to 1 immediately (asynchronous), discards the frame, emits no frame_done, and does not re-offer the aborted frame.
REQ-027 First accept is possible in the first clock cycle after rstn deasserts.

Verification
REQ-028 Requester 0 sends 7'h55, STOP_BITS=1 -> serial_out 0,1,0,1,0,1,0,1,0,1 over cycles T+1..T+10; parity 0; frame_done at T+11.
REQ-029 All four req_valid high after reset, STOP_BITS=1 -> grants in order 0,1,2,3 at accept cycles T, T+11, T+22, T+33; grant_id follows.
REQ-030 Requester 1 sends 7'h01 with req_err_inject[1]=1 -> parity bit 0 instead of 1; the downstream receiver reports a parity error.
REQ-031 rstn pulsed low during data bit 3 -> serial_out=1 within the reset cycle, busy=0, no frame_done; a next request from requester 0 wins first.
REQ-032 Only requester 2 valid continuously, STOP_BITS=3 -> frames every 13 cycles, three stop cycles of 1, grant_id=2 throughout.
REQ-033 Loopback into the team serial receiver with random 7-bit data and mixed err_inject -> data_out matches payload; parity error flagged exactly when inject was set.
